// File: rtl/mu0_pkg.sv
// Shared types for the MU0 CPU with a waitrequest memory bus.
//   opcode_t : 4-bit instruction opcodes (0-8 defined, 9-15 fault)
//   state_t  : CPU control states
package mu0_pkg;

    localparam int unsigned OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OpLda = 4'd0,
        OpSto = 4'd1,
        OpAdd = 4'd2,
        OpSub = 4'd3,
        OpJmp = 4'd4,
        OpJge = 4'd5,
        OpJne = 4'd6,
        OpStp = 4'd7,
        OpOut = 4'd8
    } opcode_t;

    // Halted is the all-zeros encoding so a zero-initialised state register powers up halted.
    typedef enum logic [2:0] {
        StHalted   = 3'd0,
        StFetch    = 3'd1,
        StDecode   = 3'd2,
        StExecRd   = 3'd3,
        StExecData = 3'd4,
        StExecWr   = 3'd5
    } state_t;

endpackage

// File: rtl/mu0_alu.sv
// Combinational MU0 datapath.
//   op         : opcode being executed
//   acc        : current accumulator
//   operand    : memory operand (readdata)
//   acc_next   : accumulator result for LDA/ADD/SUB, else acc unchanged
//   jump_taken : branch decision for JMP/JGE/JNE
module mu0_alu
    import mu0_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] acc_next,
    output logic              jump_taken
);

    always_comb begin
        acc_next   = acc;
        jump_taken = 1'b0;
        case (op)
            OpLda:   acc_next   = operand;
            OpAdd:   acc_next   = acc + operand;
            OpSub:   acc_next   = acc - operand;
            OpJmp:   jump_taken = 1'b1;
            OpJge:   jump_taken = ~acc[DATA_W-1];
            OpJne:   jump_taken = |acc;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_mu0_stall.sv
// MU0 CPU on a shared instruction/data bus with waitrequest stalls.
//   clk, rst    : clock, synchronous active-high reset
//   running     : high unless halted
//   fault       : sticky, set by an undefined opcode
//   address/read/write/writedata : bus request, held while waitrequest is high
//   waitrequest : memory stall
//   readdata    : read data, valid the cycle after a read is accepted
//   out_valid   : one-cycle pulse per OUT instruction
//   out_data    : ACC captured by the last OUT
module cpu_mu0_stall
    import mu0_pkg::*;
#(
    parameter int unsigned DATA_W   = 16, // must be >= 8
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       running,
    output logic                       fault,
    output logic [DATA_W-OPCODE_W-1:0] address,
    output logic                       read,
    output logic                       write,
    output logic [DATA_W-1:0]          writedata,
    input  logic                       waitrequest,
    input  logic [DATA_W-1:0]          readdata,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data
);

    localparam int unsigned ADDR_W = DATA_W - OPCODE_W;
    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic                fault_q, fault_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [OPCODE_W-1:0] dec_op;
    logic [ADDR_W-1:0]   dec_s;
    logic [ADDR_W-1:0]   pc_inc;
    logic                accepted;
    opcode_t             alu_op;
    logic [DATA_W-1:0]   alu_acc;
    logic                alu_jump;

    assign dec_op = readdata[DATA_W-1 -: OPCODE_W];
    assign dec_s  = readdata[ADDR_W-1:0];
    assign pc_inc = pc_q + 1'b1;

    // In DECODE the instruction is still on readdata; later states use the latched IR.
    assign alu_op = opcode_t'((state_q == StDecode) ? dec_op : ir_q[DATA_W-1 -: OPCODE_W]);

    mu0_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op         (alu_op),
        .acc        (acc_q),
        .operand    (readdata),
        .acc_next   (alu_acc),
        .jump_taken (alu_jump)
    );

    // Bus outputs decode from the state register only, so they hold through stalls.
    always_comb begin
        read      = (state_q == StFetch) || (state_q == StExecRd);
        write     = (state_q == StExecWr);
        address   = (state_q == StFetch) ? pc_q : ir_q[ADDR_W-1:0];
        writedata = acc_q;
    end

    assign accepted = (read || write) && !waitrequest;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        fault_d     = fault_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            StFetch: begin
                if (accepted) state_d = StDecode;
            end
            StDecode: begin
                ir_d = readdata;
                case (dec_op)
                    OpLda, OpAdd, OpSub: begin
                        pc_d    = pc_inc;
                        state_d = StExecRd;
                    end
                    OpSto: begin
                        pc_d    = pc_inc;
                        state_d = StExecWr;
                    end
                    OpJmp, OpJge, OpJne: begin
                        pc_d    = alu_jump ? dec_s : pc_inc;
                        state_d = StFetch;
                    end
                    OpStp: state_d = StHalted;
                    OpOut: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_inc;
                        state_d     = StFetch;
                    end
                    default: begin
                        fault_d = 1'b1;
                        state_d = StHalted;
                    end
                endcase
            end
            StExecRd: begin
                if (accepted) state_d = StExecData;
            end
            StExecData: begin
                acc_d   = alu_acc;
                state_d = StFetch;
            end
            StExecWr: begin
                if (accepted) state_d = StFetch;
            end
            default: state_d = StHalted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= ResetPc;
            acc_q       <= '0;
            ir_q        <= '0;
            fault_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            fault_q     <= fault_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign running   = (state_q != StHalted);
    assign fault     = fault_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
